// File: rtl/uart_arb_pkg.sv
// uart_arb_pkg: shared FSM encodings and default sizing for the UART transmit arbiter
package uart_arb_pkg;
   localparam int         DEF_N_REQ    = 3;
   localparam logic [7:0] DEF_HDR_BASE = 8'hA0;
   typedef logic [2:0] state_t;
   localparam state_t S_IDLE      = 3'd0;
   localparam state_t S_HDR       = 3'd1;
   localparam state_t S_HDR_WAIT  = 3'd2;
   localparam state_t S_WAIT_BYTE = 3'd3;
   localparam state_t S_SEND      = 3'd4;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin pick of one request, searching upward from ptr with wrap-around
module rr_arbiter #(
   parameter int N = 3,
   parameter int W = 2
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] ptr,
   output logic [N-1:0] grant,
   output logic [W-1:0] idx
);
   logic [W-1:0] cand;

   function automatic int wrap(input int i);
      return (i >= N) ? i - N : i;
   endfunction

   // scan from the farthest slot back to ptr so the nearest request wins
   always_comb begin
      grant = '0;
      idx   = '0;
      cand  = '0;
      for (int i = N - 1; i >= 0; i--) begin
         cand = W'(wrap(int'(ptr) + i));
         if (req[cand]) begin
            grant       = '0;
            grant[cand] = 1'b1;
            idx         = cand;
         end
      end
   end
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART transmitter among N_REQ byte streams, each burst
// prefixed by a header byte naming its source; stalled bursts are aborted after MAX_GAP cycles.
module uart_tx_arbiter
   import uart_arb_pkg::*;
#(
   parameter int         N_REQ    = DEF_N_REQ,
   parameter logic [7:0] HDR_BASE = DEF_HDR_BASE,
   parameter int         MAX_GAP  = 1023
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic [N_REQ-1:0]   i_valid,
   input  logic [8*N_REQ-1:0] i_data,
   input  logic [N_REQ-1:0]   i_last,
   output logic [N_REQ-1:0]   o_ack,
   output logic               o_tx_dv,
   output logic [7:0]         o_tx_byte,
   input  logic               i_tx_active,
   input  logic               i_tx_done,
   output logic [N_REQ-1:0]   o_grant,
   output logic               o_busy,
   output logic               o_timeout
);
   localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int GW = $clog2(MAX_GAP + 1);

   state_t          state;
   logic [IW-1:0]   rr, g, g_next, pick_idx;
   logic [N_REQ-1:0] pick_grant;
   logic [GW-1:0]   gap;
   logic            last_q;
   logic [7:0]      cur_data;

   rr_arbiter #(.N(N_REQ), .W(IW)) u_pick (
      .req  (i_valid),
      .ptr  (rr),
      .grant(pick_grant),
      .idx  (pick_idx)
   );

   assign cur_data = i_data[8*int'(g) +: 8];
   assign g_next   = (g == IW'(N_REQ - 1)) ? '0 : g + IW'(1);
   assign o_busy   = state != S_IDLE;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state     <= S_IDLE;
         rr        <= '0;
         g         <= '0;
         gap       <= '0;
         last_q    <= 1'b0;
         o_grant   <= '0;
         o_ack     <= '0;
         o_tx_dv   <= 1'b0;
         o_tx_byte <= '0;
         o_timeout <= 1'b0;
      end else begin
         o_ack     <= '0;
         o_tx_dv   <= 1'b0;
         o_timeout <= 1'b0;
         case (state)
            S_IDLE: if (|i_valid && !i_tx_active) begin
               g         <= pick_idx;
               o_grant   <= pick_grant;
               o_tx_byte <= HDR_BASE | 8'(pick_idx);
               o_tx_dv   <= 1'b1;
               state     <= S_HDR;
            end
            S_HDR: state <= S_HDR_WAIT;
            S_HDR_WAIT: if (i_tx_done) begin
               gap   <= '0;
               state <= S_WAIT_BYTE;
            end
            // ack and start pulse leave together from registers, one cycle after capture
            S_WAIT_BYTE: if (i_valid[g]) begin
               o_tx_byte <= cur_data;
               last_q    <= i_last[g];
               o_ack     <= o_grant;
               o_tx_dv   <= 1'b1;
               state     <= S_SEND;
            end else if (gap == GW'(MAX_GAP - 1)) begin
               o_timeout <= 1'b1;
               rr        <= g_next;
               o_grant   <= '0;
               state     <= S_IDLE;
            end else gap <= gap + GW'(1);
            S_SEND: if (i_tx_done) begin
               if (last_q) begin
                  rr      <= g_next;
                  o_grant <= '0;
                  state   <= S_IDLE;
               end else begin
                  gap   <= '0;
                  state <= S_WAIT_BYTE;
               end
            end
            default: begin
               o_grant <= '0;
               state   <= S_IDLE;
            end
         endcase
      end
   end
endmodule
